// File: rtl/tpu_pkg.sv
// Shared opcodes, FSM state encoding and width helpers for the TPU command controller.
package tpu_pkg;

  localparam logic [2:0] OpNop      = 3'b000;
  localparam logic [2:0] OpWrInput  = 3'b001;
  localparam logic [2:0] OpWrWeight = 3'b010;
  localparam logic [2:0] OpLoadFifo = 3'b011;
  localparam logic [2:0] OpMatmul   = 3'b100;
  localparam logic [2:0] OpRdOutput = 3'b101;
  localparam logic [2:0] OpRsvd     = 3'b110;
  localparam logic [2:0] OpClear    = 3'b111;

  typedef enum logic [3:0] {
    StIdle,
    StWrIn,
    StWrWt,
    StFifoClr,
    StFifoRd,
    StMmStart,
    StMmWait,
    StRdOut,
    StClr,
    StDone
  } state_e;

  // Dimension field width: rows-1 for an array edge of wh.
  function automatic int unsigned calc_dw(int unsigned wh);
    return (wh > 1) ? $clog2(wh) : 1;
  endfunction

  // Sub-matrix coordinate width: number of array tiles along a max-size matrix edge.
  function automatic int unsigned calc_sw(int unsigned max_wh, int unsigned wh);
    return ((max_wh / wh) > 1) ? $clog2(max_wh / wh) : 1;
  endfunction

endpackage

// File: rtl/tpu_row_seq.sv
// Loadable row sequencer: walks count_i+1 rows starting at base_i, one row per step.
module tpu_row_seq
  import tpu_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          load_i,
  input  logic [AW-1:0] base_i,
  input  logic [CW-1:0] count_i,
  input  logic          step_i,
  output logic [AW-1:0] addr_o,
  output logic          active_o,
  output logic          last_o
);

  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] remain_q, remain_d;
  logic          active_q, active_d;

  // Load has priority; a step on the final row retires the sequence.
  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    active_d = active_q;
    if (load_i) begin
      addr_d   = base_i;
      remain_d = count_i;
      active_d = 1'b1;
    end else if (step_i && active_q) begin
      if (remain_q == '0) begin
        active_d = 1'b0;
      end else begin
        addr_d   = addr_q + AW'(1);
        remain_d = remain_q - CW'(1);
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q   <= '0;
      remain_q <= '0;
      active_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
      active_q <= active_d;
    end
  end

  assign addr_o   = addr_q;
  assign active_o = active_q;
  assign last_o   = active_q && (remain_q == '0);

endmodule

// File: rtl/tpu_cmd_ctrl.sv
// Host command responder: latches one command per start and sequences datapath strobes.
module tpu_cmd_ctrl
  import tpu_pkg::*;
#(
  parameter int unsigned WIDTH_HEIGHT = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_MAT_WH   = 128,
  parameter int unsigned ADDR_WIDTH   = 8,
  localparam int unsigned DW = calc_dw(WIDTH_HEIGHT),
  localparam int unsigned SW = calc_sw(MAX_MAT_WH, WIDTH_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            opcode,
  input  logic [DW-1:0]         dim_1,
  input  logic [DW-1:0]         dim_2,
  input  logic [DW-1:0]         dim_3,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [SW-1:0]         accum_table_submat_row_in,
  input  logic [SW-1:0]         accum_table_submat_col_in,
  output logic                  done,
  output logic                  fifo_ready,
  output logic                  in_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] in_mem_addr,
  output logic                  wt_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] wt_mem_addr,
  output logic                  wt_mem_rd_en,
  output logic                  fifo_wr_en,
  output logic                  fifo_clr,
  output logic                  mmu_start,
  input  logic                  mmu_done,
  output logic [DW-1:0]         mmu_rows,
  output logic [DW-1:0]         mmu_k,
  output logic [DW-1:0]         mmu_cols,
  output logic [ADDR_WIDTH-1:0] mmu_addr,
  output logic [SW-1:0]         submat_row,
  output logic [SW-1:0]         submat_col,
  output logic                  out_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  output logic                  accum_clr
);

  // Data is only routed past this block; reject a degenerate element width at elaboration.
  if (DATA_WIDTH == 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be nonzero");
  end

  state_e                state_q, state_d;
  logic [DW-1:0]         dim1_q, dim1_d, dim2_q, dim2_d, dim3_q, dim3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SW-1:0]         srow_q, srow_d, scol_q, scol_d;
  logic                  fifo_ready_q, fifo_ready_d;
  logic                  fifo_wr_q, fifo_wr_d;

  logic                  seq_load, seq_step, seq_active, seq_last;
  logic [ADDR_WIDTH-1:0] seq_addr;

  tpu_row_seq #(
    .AW (ADDR_WIDTH),
    .CW (DW)
  ) u_row_seq (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (seq_load),
    .base_i   (addr_1),
    .count_i  (dim_1),
    .step_i   (seq_step),
    .addr_o   (seq_addr),
    .active_o (seq_active),
    .last_o   (seq_last)
  );

  assign seq_step = (state_q == StWrIn) || (state_q == StWrWt) ||
                    (state_q == StFifoRd) || (state_q == StRdOut);

  // Next-state, command field latching and fifo_ready tracking.
  always_comb begin
    state_d      = state_q;
    dim1_d       = dim1_q;
    dim2_d       = dim2_q;
    dim3_d       = dim3_q;
    addr_d       = addr_q;
    srow_d       = srow_q;
    scol_d       = scol_q;
    fifo_ready_d = fifo_ready_q;
    seq_load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // NOP and the reserved code leave every latched output untouched.
          if (opcode != OpNop && opcode != OpRsvd) begin
            dim1_d = dim_1;
            dim2_d = dim_2;
            dim3_d = dim_3;
            addr_d = addr_1;
            srow_d = accum_table_submat_row_in;
            scol_d = accum_table_submat_col_in;
          end
          case (opcode)
            OpWrInput:  begin state_d = StWrIn;    seq_load = 1'b1; end
            OpWrWeight: begin state_d = StWrWt;    seq_load = 1'b1; end
            OpRdOutput: begin state_d = StRdOut;   seq_load = 1'b1; end
            OpLoadFifo: begin
              state_d      = StFifoClr;
              seq_load     = 1'b1;
              fifo_ready_d = 1'b0;
            end
            OpMatmul:   state_d = fifo_ready_q ? StMmStart : StDone;
            OpClear:    begin state_d = StClr; fifo_ready_d = 1'b0; end
            default:    state_d = StDone;
          endcase
        end
      end
      StWrIn, StWrWt, StFifoRd, StRdOut: if (seq_last) state_d = StDone;
      StFifoClr: state_d = StFifoRd;
      StMmStart: state_d = StMmWait;
      StMmWait: begin
        if (mmu_done) begin
          state_d      = StDone;
          fifo_ready_d = 1'b0;
        end
      end
      StClr: state_d = StDone;
      StDone: begin
        // Hold done back until the trailing FIFO push of a load has been issued.
        if (fifo_wr_q) fifo_ready_d = 1'b1;
        else           state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      dim1_q       <= '0;
      dim2_q       <= '0;
      dim3_q       <= '0;
      addr_q       <= '0;
      srow_q       <= '0;
      scol_q       <= '0;
      fifo_ready_q <= 1'b0;
      fifo_wr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dim1_q       <= dim1_d;
      dim2_q       <= dim2_d;
      dim3_q       <= dim3_d;
      addr_q       <= addr_d;
      srow_q       <= srow_d;
      scol_q       <= scol_d;
      fifo_ready_q <= fifo_ready_d;
      fifo_wr_q    <= fifo_wr_d;
    end
  end

  // Strobes decoded from state; addresses are zero whenever their strobe is idle.
  always_comb begin
    in_mem_wr_en  = (state_q == StWrIn) && seq_active;
    wt_mem_wr_en  = (state_q == StWrWt) && seq_active;
    wt_mem_rd_en  = (state_q == StFifoRd) && seq_active;
    out_mem_rd_en = (state_q == StRdOut) && seq_active;
    in_mem_addr   = in_mem_wr_en ? seq_addr : '0;
    wt_mem_addr   = (wt_mem_wr_en || wt_mem_rd_en) ? seq_addr : '0;
    out_mem_addr  = out_mem_rd_en ? seq_addr : '0;
    fifo_wr_d     = wt_mem_rd_en;
    fifo_clr      = (state_q == StFifoClr) || (state_q == StClr);
    accum_clr     = (state_q == StClr);
    mmu_start     = (state_q == StMmStart);
    done          = (state_q == StDone) && !fifo_wr_q;
  end

  assign fifo_wr_en = fifo_wr_q;
  assign fifo_ready = fifo_ready_q;
  assign mmu_rows   = dim1_q;
  assign mmu_k      = dim2_q;
  assign mmu_cols   = dim3_q;
  assign mmu_addr   = addr_q;
  assign submat_row = srow_q;
  assign submat_col = scol_q;

endmodule
